// File: rtl/traceback_unit.sv
// Frame-based K=3 survivor memory + traceback; first bit FRAME_LEN+1 cycles after last step accept.
// Backpressure: ready_in low while tracing/emitting; bit_out/frame_last held until bit_ready.
module traceback_unit #(
  parameter int FRAME_LEN = 8,
  parameter int PM_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic            dec_00,
  input  logic            dec_01,
  input  logic            dec_10,
  input  logic            dec_11,
  input  logic [PM_W-1:0] pm_00,
  input  logic [PM_W-1:0] pm_01,
  input  logic [PM_W-1:0] pm_10,
  input  logic [PM_W-1:0] pm_11,
  output logic            bit_out,
  output logic            bit_valid,
  input  logic            bit_ready,
  output logic            frame_last,
  output logic            busy
);

  localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {COLLECT, TRACE, OUTPUT} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                ready_nxt, busy_nxt, bit_vld_nxt, bit_out_nxt, last_nxt;
  logic                accept;
  logic [3:0]          dbuf [FRAME_LEN];
  logic [FRAME_LEN-1:0] obuf;
  logic [1:0]          tb_state, best_state;
  logic [PM_W-1:0]     best_pm;

  assign accept = valid_in && ready_in;

  // Strict less-than keeps the lowest-index state on ties.
  always_comb begin
    best_state = 2'd0;
    best_pm    = pm_00;
    if (pm_01 < best_pm) begin best_state = 2'd1; best_pm = pm_01; end
    if (pm_10 < best_pm) begin best_state = 2'd2; best_pm = pm_10; end
    if (pm_11 < best_pm) begin best_state = 2'd3; best_pm = pm_11; end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_vld_nxt = bit_valid;
    bit_out_nxt = bit_out;
    last_nxt    = frame_last;
    unique case (state)
      COLLECT: begin
        if (accept) begin
          if (cnt == LAST) begin
            state_nxt = TRACE;
            cnt_nxt   = LAST;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      TRACE: begin
        if (cnt == '0) state_nxt = OUTPUT;
        else           cnt_nxt   = cnt - 1'b1;
      end
      OUTPUT: begin
        // First OUTPUT cycle loads bit 0, since obuf[0] lands on the last TRACE edge.
        if (!bit_valid) begin
          bit_vld_nxt = 1'b1;
          bit_out_nxt = obuf[0];
          last_nxt    = 1'b0;
        end else if (bit_ready) begin
          if (cnt == LAST) begin
            state_nxt   = COLLECT;
            cnt_nxt     = '0;
            bit_vld_nxt = 1'b0;
            bit_out_nxt = 1'b0;
            last_nxt    = 1'b0;
          end else begin
            cnt_nxt     = cnt + 1'b1;
            bit_out_nxt = obuf[cnt_nxt];
            last_nxt    = (cnt_nxt == LAST);
          end
        end
      end
      default: begin
        state_nxt = COLLECT;
        cnt_nxt   = '0;
      end
    endcase
    ready_nxt = (state_nxt == COLLECT);
    busy_nxt  = !ready_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      cnt        <= '0;
      ready_in   <= 1'b1;
      busy       <= 1'b0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ready_in   <= ready_nxt;
      busy       <= busy_nxt;
      bit_valid  <= bit_vld_nxt;
      bit_out    <= bit_out_nxt;
      frame_last <= last_nxt;
    end
  end

  // Decision and decoded-bit storage need no reset; a fresh frame overwrites them.
  always_ff @(posedge clk) begin
    if (accept) begin
      dbuf[cnt] <= {dec_11, dec_10, dec_01, dec_00};
      if (cnt == LAST) tb_state <= best_state;
    end
    if (state == TRACE) begin
      obuf[cnt] <= tb_state[1];
      tb_state  <= {tb_state[0], dbuf[cnt][tb_state]};
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed-vector bench for traceback_unit with FRAME_LEN=4, PM_W=4.
module tb_traceback_unit;

  logic       clk = 1'b0;
  logic       rst, valid_in, ready_in;
  logic       dec_00, dec_01, dec_10, dec_11;
  logic [3:0] pm_00, pm_01, pm_10, pm_11;
  logic       bit_out, bit_valid, bit_ready, frame_last, busy;

  int checks = 0;
  int errors = 0;

  traceback_unit #(.FRAME_LEN(4), .PM_W(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .dec_00(dec_00), .dec_01(dec_01), .dec_10(dec_10), .dec_11(dec_11),
    .pm_00(pm_00), .pm_01(pm_01), .pm_10(pm_10), .pm_11(pm_11),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .frame_last(frame_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // dec: step i decisions {d11,d10,d01,d00} at [4i+:4]; pm: {pm_11,pm_10,pm_01,pm_00}; bits[j] = j-th emitted bit
  typedef struct {
    logic [15:0] dec;
    logic [15:0] pm;
    logic [3:0]  bits;
  } vec_t;

  vec_t vecs [6];
  localparam logic [15:0] DECOY_PM = 16'h0FFF;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_step(input logic [3:0] d, input logic [15:0] pm, input int gap);
    int n;
    valid_in = 1'b0;
    {dec_11, dec_10, dec_01, dec_00} = ~d;
    repeat (gap) @(negedge clk);
    {dec_11, dec_10, dec_01, dec_00} = d;
    {pm_11, pm_10, pm_01, pm_00} = pm;
    valid_in = 1'b1;
    n = 0;
    while (!ready_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] dec, input logic [15:0] pm, input int gap);
    for (int i = 0; i < 4; i++)
      push_step(dec[4*i +: 4], (i == 3) ? pm : DECOY_PM, gap);
  endtask

  // Called at the negedge right after the last accept edge.
  task automatic collect_bits(input logic [3:0] exp, input int sj, input int sn);
    int lat;
    check("busy_trace", {31'd0, busy}, 32'd1);
    check("ready_trace", {31'd0, ready_in}, 32'd0);
    lat = 0;
    while (!bit_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("first_bit_latency", lat, 32'd5);
    for (int j = 0; j < 4; j++) begin
      if (j == sj) begin
        bit_ready = 1'b0;
        repeat (sn) begin
          @(negedge clk);
          check("stall_valid", {31'd0, bit_valid}, 32'd1);
          check("stall_bit", {31'd0, bit_out}, {31'd0, exp[j]});
          check("stall_last", {31'd0, frame_last}, (j == 3) ? 32'd1 : 32'd0);
          check("stall_ready_in", {31'd0, ready_in}, 32'd0);
        end
        bit_ready = 1'b1;
      end
      check("bit_valid", {31'd0, bit_valid}, 32'd1);
      check("bit_out", {31'd0, bit_out}, {31'd0, exp[j]});
      check("frame_last", {31'd0, frame_last}, (j == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("end_bit_valid", {31'd0, bit_valid}, 32'd0);
    check("end_ready_in", {31'd0, ready_in}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_reset_and_check(input string nm);
    int seen;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({nm, "_ready_in"}, {31'd0, ready_in}, 32'd1);
    check({nm, "_bit_valid"}, {31'd0, bit_valid}, 32'd0);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bit_valid) seen++;
    end
    check({nm, "_no_bits"}, seen, 32'd0);
  endtask

  initial begin
    vecs[0] = '{dec: 16'h0000, pm: 16'h5055, bits: 4'b1000};
    vecs[1] = '{dec: 16'hFFFF, pm: 16'h3333, bits: 4'b0011};
    vecs[2] = '{dec: 16'hFFFF, pm: 16'h0999, bits: 4'b1111};
    vecs[3] = '{dec: 16'hA0F0, pm: 16'h9919, bits: 4'b0110};
    vecs[4] = '{dec: 16'h6666, pm: 16'h2237, bits: 4'b1011};
    vecs[5] = '{dec: 16'h0000, pm: 16'hE98F, bits: 4'b0100};

    rst = 1'b1; valid_in = 1'b0; bit_ready = 1'b1;
    {dec_11, dec_10, dec_01, dec_00} = 4'h0;
    {pm_11, pm_10, pm_01, pm_00} = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_ready_in", {31'd0, ready_in}, 32'd1);
    check("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
    check("rst_bit_out", {31'd0, bit_out}, 32'd0);
    check("rst_frame_last", {31'd0, frame_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].dec, vecs[v].pm, 0);
      collect_bits(vecs[v].bits, -1, 0);
    end

    // Backpressure mid-frame and on the final bit.
    send_frame(vecs[3].dec, vecs[3].pm, 0);
    collect_bits(vecs[3].bits, 2, 3);
    send_frame(vecs[4].dec, vecs[4].pm, 0);
    collect_bits(vecs[4].bits, 3, 2);

    // valid_in held high while busy must not be accepted.
    send_frame(vecs[1].dec, vecs[1].pm, 0);
    valid_in = 1'b1;
    {dec_11, dec_10, dec_01, dec_00} = 4'h9;
    collect_bits(vecs[1].bits, -1, 0);
    valid_in = 1'b0;
    send_frame(vecs[2].dec, vecs[2].pm, 0);
    collect_bits(vecs[2].bits, -1, 0);

    // valid_in toggling with garbage decisions in the idle cycles.
    send_frame(vecs[0].dec, vecs[0].pm, 1);
    collect_bits(vecs[0].bits, -1, 0);

    // Reset mid-TRACE.
    send_frame(vecs[2].dec, vecs[2].pm, 0);
    @(negedge clk);
    pulse_reset_and_check("rst_trace");
    send_frame(vecs[0].dec, vecs[0].pm, 0);
    collect_bits(vecs[0].bits, -1, 0);

    // Reset mid-OUTPUT after one bit has been taken.
    send_frame(vecs[1].dec, vecs[1].pm, 0);
    begin
      int n;
      n = 0;
      while (!bit_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rst_out_wait", {31'd0, bit_valid}, 32'd1);
    end
    @(negedge clk);
    pulse_reset_and_check("rst_output");
    send_frame(vecs[0].dec, vecs[0].pm, 0);
    collect_bits(vecs[0].bits, -1, 0);

    // Partial frame discarded by reset; step counter restarts.
    push_step(4'h0, DECOY_PM, 0);
    push_step(4'h0, DECOY_PM, 0);
    pulse_reset_and_check("rst_partial");
    send_frame(vecs[1].dec, vecs[1].pm, 0);
    collect_bits(vecs[1].bits, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
